// File: rtl/rheed_result_packer.sv
// Purpose: gathers one 40-bit result per crop and packs a frame into 256-bit host words (6 slots + 16-bit frame header).
// Latency: first word is valid the cycle after the last crop result is captured; further words issue back-to-back.
// Backpressure: crop inputs stall per crop once captured until the frame is sent; output word/tlast held while m_axis_tready=0.
module rheed_result_packer #(
  parameter int NUM_CROPS = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_CROPS-1:0] s_axis_tvalid,
  output logic [NUM_CROPS-1:0] s_axis_tready,
  input  logic [39:0]          s_axis_tdata [NUM_CROPS],
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [255:0]         m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic [15:0]          frame_cnt
);

  // Six 40-bit slots per word; the top 16 bits carry the frame header.
  localparam int NUM_WORDS = (NUM_CROPS + 5) / 6;
  localparam int WIDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(NUM_WORDS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 rst_done_q, rst_done_d;
  logic [NUM_CROPS-1:0] have_q, have_d;
  logic [39:0]          res_q [NUM_CROPS];
  logic [39:0]          res_d [NUM_CROPS];
  logic [WIDX_W-1:0]    widx_q, widx_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 m_tvalid_q, m_tvalid_d;
  logic [255:0]         m_tdata_q, m_tdata_d;
  logic                 m_tlast_q, m_tlast_d;
  logic [NUM_CROPS-1:0] capture;

  // Build output word w: crop i lands in word i/6, slot i%6; unused slots stay zero.
  function automatic logic [255:0] pack_word(input logic [39:0] res [NUM_CROPS],
                                             input logic [WIDX_W-1:0] w,
                                             input logic [15:0] hdr);
    logic [255:0] word;
    word = '0;
    for (int i = 0; i < NUM_CROPS; i++) begin
      if ((i / 6) == int'(w)) begin
        word[40*(i%6) +: 40] = res[i];
      end
    end
    word[255:240] = hdr;
    return word;
  endfunction

  // Crop inputs only open in COLLECT, after the reset-release edge, for crops not yet held.
  assign s_axis_tready = (state_q == COLLECT && rst_done_q) ? ~have_q : '0;

  // Everything downstream-facing comes straight from flops.
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tlast  = m_tlast_q;
  assign frame_cnt     = frame_cnt_q;

  // Next-state: capture crop results, then walk the output words of the frame.
  always_comb begin
    state_d     = state_q;
    rst_done_d  = 1'b1;
    have_d      = have_q;
    res_d       = res_q;
    widx_d      = widx_q;
    frame_cnt_d = frame_cnt_q;
    m_tvalid_d  = m_tvalid_q;
    m_tdata_d   = m_tdata_q;
    m_tlast_d   = m_tlast_q;
    capture     = '0;

    case (state_q)
      COLLECT: begin
        capture = s_axis_tvalid & s_axis_tready;
        for (int i = 0; i < NUM_CROPS; i++) begin
          if (capture[i]) begin
            res_d[i] = s_axis_tdata[i];
          end
        end
        have_d = have_q | capture;
        // Word 0 is formed from res_d so the last arrivals appear without an extra cycle.
        if (&have_d) begin
          state_d    = SEND;
          widx_d     = '0;
          m_tvalid_d = 1'b1;
          m_tdata_d  = pack_word(res_d, {WIDX_W{1'b0}}, frame_cnt_q);
          m_tlast_d  = (NUM_WORDS == 1);
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          if (widx_q == LAST_WIDX) begin
            state_d     = COLLECT;
            have_d      = '0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            m_tvalid_d  = 1'b0;
            m_tdata_d   = '0;
            m_tlast_d   = 1'b0;
          end else begin
            widx_d    = widx_q + 1'b1;
            m_tdata_d = pack_word(res_q, widx_d, frame_cnt_q);
            m_tlast_d = (widx_d == LAST_WIDX);
          end
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State registers; reset discards any partial or in-flight frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= COLLECT;
      rst_done_q  <= 1'b0;
      have_q      <= '0;
      for (int i = 0; i < NUM_CROPS; i++) begin
        res_q[i] <= '0;
      end
      widx_q      <= '0;
      frame_cnt_q <= '0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tlast_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_done_q  <= rst_done_d;
      have_q      <= have_d;
      for (int i = 0; i < NUM_CROPS; i++) begin
        res_q[i] <= res_d[i];
      end
      widx_q      <= widx_d;
      frame_cnt_q <= frame_cnt_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tdata_q   <= m_tdata_d;
      m_tlast_q   <= m_tlast_d;
    end
  end

endmodule
